// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and helpers for the scoreboarded register bank
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int POP_MAX    = 256;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Callers size-cast narrower vectors up to POP_MAX before counting.
  function automatic int popcount(input logic [POP_MAX-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits with set-over-clear priority and popcount
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rsv,
  input  logic [ADDR_W-1:0]   rsv_a,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wa,
  output logic [2**ADDR_W-1:0] pend,
  output logic [ADDR_W:0]     nbusy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pend_next;

  // A new producer supersedes the one completing in the same cycle.
  always_comb begin
    pend_next = pend;
    for (int i = 0; i < DEPTH; i++) begin
      if (rsv && (rsv_a == ADDR_W'(i)))
        pend_next[i] = 1'b1;
      else if (we && (wa == ADDR_W'(i)))
        pend_next[i] = 1'b0;
    end
    if (ZERO_REG != 0)
      pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= '0;
      nbusy <= '0;
    end else begin
      pend  <= pend_next;
      nbusy <= (ADDR_W+1)'(popcount(POP_MAX'(pend_next)));
    end
  end

endmodule

// File: rtl/banco_registros_sb.sv
// rtl/banco_registros_sb.sv - multi-port register bank with zero register, forwarding and scoreboard
module banco_registros_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_RD*ADDR_W-1:0]   ra,
  output logic [N_RD*DATA_W-1:0]   dr,
  output logic [N_RD-1:0]          rbusy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     rsv,
  input  logic [ADDR_W-1:0]        rsv_a,
  output logic [2**ADDR_W-1:0]     pend,
  output logic [ADDR_W:0]          nbusy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] banco [DEPTH];
  logic              wr_ok;

  assign wr_ok = we && !((ZERO_REG != 0) && (wa == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) banco[i] <= '0;
    end else if (wr_ok) begin
      banco[wa] <= wd;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk   (clk),
    .rst_n (rst_n),
    .rsv   (rsv),
    .rsv_a (rsv_a),
    .we    (we),
    .wa    (wa),
    .pend  (pend),
    .nbusy (nbusy)
  );

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    logic              fwd;
    logic              rsv_hit;

    assign ra_k    = ra[k*ADDR_W +: ADDR_W];
    assign fwd     = (BYPASS != 0) && we && (wa == ra_k);
    assign rsv_hit = rsv && (rsv_a == ra_k);

    // Reset gating keeps a stray write strobe from forwarding while rst_n is low.
    always_comb begin
      dr[k*DATA_W +: DATA_W] = banco[ra_k];
      rbusy[k]               = pend[ra_k];
      if (!rst_n) begin
        dr[k*DATA_W +: DATA_W] = '0;
        rbusy[k]               = 1'b0;
      end else if ((ZERO_REG != 0) && (ra_k == '0)) begin
        dr[k*DATA_W +: DATA_W] = '0;
        rbusy[k]               = 1'b0;
      end else if (fwd) begin
        dr[k*DATA_W +: DATA_W] = wd;
        if (!rsv_hit) rbusy[k] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_banco_registros_sb.sv
// tb/tb_banco_registros_sb.sv - directed self-checking bench for banco_registros_sb
module tb_banco_registros_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] dr;
  logic [NR-1:0] rbusy;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic          rsv;
  logic [AW-1:0] rsv_a;
  logic [31:0]   pend;
  logic [AW:0]   nbusy;

  logic [AW-1:0] ra_nb;
  logic [DW-1:0] dr_nb;
  logic [0:0]    rbusy_nb;
  logic [31:0]   pend_nb;
  logic [AW:0]   nbusy_nb;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  banco_registros_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .dr(dr), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .rsv(rsv), .rsv_a(rsv_a),
    .pend(pend), .nbusy(nbusy)
  );

  banco_registros_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(1), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ra(ra_nb), .dr(dr_nb), .rbusy(rbusy_nb),
    .we(we), .wa(wa), .wd(wd), .rsv(rsv), .rsv_a(rsv_a),
    .pend(pend_nb), .nbusy(nbusy_nb)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return dr[k*DW +: DW];
  endfunction

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    ra[k*AW +: AW] = a;
  endtask

  initial begin
    rst_n = 1'b0; ra = '0; ra_nb = '0; we = 1'b0; wa = '0; wd = '0; rsv = 1'b0; rsv_a = '0;
    repeat (2) @(negedge clk);
    check("reset_pend", 64'(pend), 64'h0);
    check("reset_nbusy", 64'(nbusy), 64'h0);
    rst_n = 1'b1;

    // write r5 then asynchronous reset mid-run
    @(negedge clk); we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    @(negedge clk); we = 1'b0; set_ra(0, 5'd5); #1;
    check("r5_written", 64'(rd(0)), 64'hDEADBEEF);
    rst_n = 1'b0; #1;
    check("rst_dr_async", 64'(rd(0)), 64'h0);
    check("rst_pend", 64'(pend), 64'h0);
    check("rst_nbusy", 64'(nbusy), 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    check("r5_after_reset", 64'(rd(0)), 64'h0);

    // write with forwarding vs. without
    @(negedge clk); we = 1'b1; wa = 5'd7; wd = 32'h12345678; set_ra(0, 5'd7); ra_nb = 5'd7; #1;
    check("bypass_same_cycle", 64'(rd(0)), 64'h12345678);
    check("nobypass_old", 64'(dr_nb), 64'h0);
    @(negedge clk); we = 1'b0; #1;
    check("bypass_next", 64'(rd(0)), 64'h12345678);
    check("nobypass_next", 64'(dr_nb), 64'h12345678);

    // zero register ignores writes and reservations
    @(negedge clk); we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; rsv = 1'b1; rsv_a = 5'd0; set_ra(0, 5'd0); #1;
    check("zero_dr_same", 64'(rd(0)), 64'h0);
    check("zero_rbusy_same", 64'(rbusy[0]), 64'h0);
    @(negedge clk); we = 1'b0; rsv = 1'b0; #1;
    check("zero_dr", 64'(rd(0)), 64'h0);
    check("zero_pend0", 64'(pend[0]), 64'h0);
    check("zero_nbusy", 64'(nbusy), 64'h0);

    // scoreboard lifecycle
    @(negedge clk); rsv = 1'b1; rsv_a = 5'd3;
    @(negedge clk); rsv_a = 5'd9; set_ra(2, 5'd9); #1;
    check("rsv_same_cycle_rbusy", 64'(rbusy[2]), 64'h0);
    @(negedge clk); rsv = 1'b0; set_ra(1, 5'd3); #1;
    check("rsv_next_rbusy", 64'(rbusy[2]), 64'h1);
    check("sb_nbusy2", 64'(nbusy), 64'h2);
    check("sb_pend", 64'(pend), 64'h0000_0208);
    check("sb_rbusy1", 64'(rbusy[1]), 64'h1);
    @(negedge clk); we = 1'b1; wa = 5'd3; wd = 32'h000000A5; #1;
    check("clr_rbusy_same", 64'(rbusy[1]), 64'h0);
    check("clr_dr_same", 64'(rd(1)), 64'hA5);
    @(negedge clk); we = 1'b0; #1;
    check("clr_nbusy1", 64'(nbusy), 64'h1);
    check("clr_pend", 64'(pend), 64'h0000_0200);
    check("clr_dr_next", 64'(rd(1)), 64'hA5);

    // simultaneous set and clear of r4
    @(negedge clk); rsv = 1'b1; rsv_a = 5'd4;
    @(negedge clk); rsv = 1'b0; #1;
    check("r4_pending_nbusy", 64'(nbusy), 64'h2);
    @(negedge clk); we = 1'b1; wa = 5'd4; wd = 32'h55; rsv = 1'b1; rsv_a = 5'd4; set_ra(0, 5'd4); #1;
    check("setclr_rbusy_same", 64'(rbusy[0]), 64'h1);
    check("setclr_dr_same", 64'(rd(0)), 64'h55);
    @(negedge clk); we = 1'b0; rsv = 1'b0; #1;
    check("setclr_pend4", 64'(pend[4]), 64'h1);
    check("setclr_dr", 64'(rd(0)), 64'h55);
    check("setclr_nbusy", 64'(nbusy), 64'h2);

    // all four ports reading the same register
    @(negedge clk); we = 1'b1; wa = 5'd12; wd = 32'h0BADF00D;
    for (int k = 0; k < NR; k++) set_ra(k, 5'd12);
    #1;
    for (int k = 0; k < NR; k++) check($sformatf("port%0d_fwd", k), 64'(rd(k)), 64'h0BADF00D);
    @(negedge clk); we = 1'b0; #1;
    for (int k = 0; k < NR; k++) check($sformatf("port%0d_rd", k), 64'(rd(k)), 64'h0BADF00D);
    check("ports_rbusy", 64'(rbusy), 64'h0);

    // fill every non-zero register's reservation
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); rsv = 1'b1; rsv_a = AW'(i);
    end
    @(negedge clk); rsv = 1'b0; #1;
    check("fill_nbusy", 64'(nbusy), 64'd31);
    check("fill_pend", 64'(pend), 64'hFFFF_FFFE);
    check("fill_rbusy", 64'(rbusy), 64'hF);

    // drain via writebacks
    for (int i = 1; i < 32; i++) begin
      @(negedge clk); we = 1'b1; wa = AW'(i); wd = 32'(i);
    end
    @(negedge clk); we = 1'b0; #1;
    check("drain_nbusy", 64'(nbusy), 64'd0);
    check("drain_pend", 64'(pend), 64'h0);
    check("drain_r12", 64'(rd(0)), 64'd12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/banco_registros_sb.md
Name: banco_registros_sb

Overview:
- Parametrised, clocked register file for the processor datapath; the next generation of the two-read/one-write register bank.
- Adds configurable width, depth and read-port count, a hardwired zero register, write-to-read forwarding, and a per-register pending scoreboard.
- The scoreboard lets the decode stage detect RAW hazards against writebacks still in flight.
- Sits between decode (read/reserve) and writeback (write/release).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- N_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never pending
- BYPASS, 1, 1 = a read of the address being written this cycle returns wd

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ra  in  N_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- dr  out  N_RD*DATA_W  read data, port k packed the same way
- rbusy  out  N_RD  port k's register has a pending (reserved, unwritten) result
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- rsv  in  1  reserve strobe: mark rsv_a as pending
- rsv_a  in  ADDR_W  register reserved by the issuing instruction
- pend  out  2**ADDR_W  raw pending vector, bit i = register i pending
- nbusy  out  ADDR_W+1  population count of pend

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers cleared to 0; all pend bits 0; nbusy 0.
  - dr and rbusy follow combinationally, so both are 0 during reset.
- Release of rst_n is sampled by the next rising clk edge; no operation takes effect in the release cycle unless rst_n is high at that edge.
- Write:
  - on rising clk with we=1, banco[wa] <= wd.
  - with ZERO_REG=1 and wa=0, the write is dropped.
- Read (combinational, zero latency):
  - dr[k] = banco[ra[k]].
  - BYPASS=1, we=1, wa=ra[k] (and not the zero register): dr[k] = wd the same cycle.
  - BYPASS=0: the new value appears the cycle after the edge.
  - ZERO_REG=1 and ra[k]=0: dr[k] = 0 regardless of contents.
- Scoreboard, per register i, at each rising clk:
  - set pend[i] when rsv=1 and rsv_a=i.
  - clear pend[i] when we=1 and wa=i.
  - both in the same cycle: set wins (a new producer supersedes the completing one), pend[i] stays 1; the data write still occurs.
  - otherwise pend[i] holds.
  - ZERO_REG=1: pend[0] is constant 0 and rsv to 0 is ignored.
  - a write to a non-pending register is legal; pend is unchanged (stays 0).
- rbusy[k] = pend[ra[k]]:
  - BYPASS=1 and a clearing write to ra[k] this cycle with no same-cycle reserve of ra[k]: rbusy[k] = 0 immediately, consistent with the forwarded dr[k].
  - a same-cycle reserve of ra[k] does not raise rbusy[k] until the next cycle.
- nbusy: registered popcount of the next pend value, so it matches pend every cycle; range 0..2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG).
- Multiple read ports with identical addresses all return identical data and busy.
- Undefined/X addresses are a stimulus error; no recovery is required.

Decomposition:
- Shared package (regfile_pkg):
  - localparam defaults for DATA_W/ADDR_W.
  - function clog2.
  - function popcount(vector) used for nbusy.
- One natural sub-module: rf_scoreboard.
  - contents: pend vector, set/clear priority, popcount register.
  - ports: clk, rst_n, rsv, rsv_a, we, wa, pend, nbusy.
- Read muxing and bypass stay in the top, generated per port.

Test Plan:
- Reset then read: pulse rst_n low mid-run after writing 0xDEADBEEF to r5 -> dr=0 immediately during reset, pend=0, nbusy=0; after release, r5 reads 0.
- Write/read with bypass:
  - we=1, wa=7, wd=0x12345678, ra[0]=7 -> dr[0]=0x12345678 in the same cycle.
  - next cycle, we=0 -> dr[0] still 0x12345678.
  - with BYPASS=0 the same-cycle dr[0] is the old value.
- Zero register: write 0xFFFFFFFF to r0, rsv to r0 -> dr=0, rbusy=0, pend[0]=0, nbusy unchanged.
- Scoreboard lifecycle:
  - rsv r3, then rsv r9 -> nbusy=2, pend bits 3 and 9 set.
  - read ra[1]=3 -> rbusy[1]=1.
  - write r3=0xA5 -> rbusy[1]=0 that cycle; dr[1]=0xA5; nbusy=1 next cycle.
- Simultaneous set/clear: r4 pending; same cycle we=1, wa=4, wd=0x55 and rsv=1, rsv_a=4 -> next cycle pend[4]=1, dr reads 0x55, nbusy unchanged.
- Port scaling: N_RD=4, all ra=12 after writing 0x0BADF00D -> all four dr equal 0x0BADF00D; fill 31 reservations -> nbusy=31.
